// File: rtl/branch_spec_tracker_if.sv
// Fetch/resolve/redirect bundle between the front end and branch_spec_tracker.
// The stats counters are present only when BRANCH_SPEC_TRACKER_STATS_EN is defined.
interface branch_spec_tracker_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 16
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                spec_valid_i;
  logic                spec_taken_i;
  logic [PC_WIDTH-1:0] spec_alt_pc_i;
  logic                spec_ready_o;
  logic [TAG_W-1:0]    spec_tag_o;
  logic                resolve_valid_i;
  logic [TAG_W-1:0]    resolve_tag_i;
  logic                resolve_taken_i;
  logic                redirect_o;
  logic [PC_WIDTH-1:0] redirect_pc_o;
  logic                flush_o;
  logic                fetch_stall_o;
  logic [TAG_W:0]      count_o;
  logic                err_o;
`ifdef BRANCH_SPEC_TRACKER_STATS_EN
  logic [15:0]         resolve_cnt_o;
  logic [15:0]         mispredict_cnt_o;
`endif

  modport slave (
    input  spec_valid_i, spec_taken_i, spec_alt_pc_i,
    input  resolve_valid_i, resolve_tag_i, resolve_taken_i,
    output spec_ready_o, spec_tag_o, redirect_o, redirect_pc_o,
    output flush_o, fetch_stall_o, count_o, err_o
`ifdef BRANCH_SPEC_TRACKER_STATS_EN
    , output resolve_cnt_o, mispredict_cnt_o
`endif
  );

  modport master (
    output spec_valid_i, spec_taken_i, spec_alt_pc_i,
    output resolve_valid_i, resolve_tag_i, resolve_taken_i,
    input  spec_ready_o, spec_tag_o, redirect_o, redirect_pc_o,
    input  flush_o, fetch_stall_o, count_o, err_o
`ifdef BRANCH_SPEC_TRACKER_STATS_EN
    , input resolve_cnt_o, mispredict_cnt_o
`endif
  );
endinterface

// File: rtl/branch_spec_tracker.sv
// In-order speculative branch checkpoint tracker with mispredict recovery sequencing.
// Optional resolve/mispredict statistics counters: define BRANCH_SPEC_TRACKER_STATS_EN.
module branch_spec_tracker #(
  parameter int DEPTH          = 4,
  parameter int PC_WIDTH       = 16,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  branch_spec_tracker_if.slave   bus
);
  localparam int TAG_W  = $clog2(DEPTH);
  localparam int RCNT_W = $clog2(RECOVER_CYCLES + 1);
  localparam logic [TAG_W:0]    FULL_CNT  = (TAG_W + 1)'(DEPTH);
  localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(RECOVER_CYCLES - 1);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t              state_reg, state_next;
  logic [RCNT_W-1:0]   rcnt_reg, rcnt_next;
  logic [TAG_W-1:0]    head_reg, tail_reg;
  logic [TAG_W:0]      count_reg, count_next;
  logic [DEPTH-1:0]    valid_reg;
  logic                taken_mem [DEPTH];
  logic [PC_WIDTH-1:0] alt_pc_mem [DEPTH];

  logic                redirect_reg, flush_reg, err_reg;
  logic [PC_WIDTH-1:0] redirect_pc_reg;

  logic spec_ready, fetch_stall;
  logic alloc, alloc_eff;
  logic res_legal, res_illegal, mispredict, correct;
  logic head_valid;

  // ---------------- handshake decode ----------------
  assign spec_ready = (state_reg == IDLE) && (count_reg != FULL_CNT);
  assign fetch_stall = (state_reg == RECOVER) || (count_reg == FULL_CNT);
  assign alloc       = bus.spec_valid_i && spec_ready;

  assign head_valid  = valid_reg[head_reg] && (count_reg != '0);
  assign res_legal   = bus.resolve_valid_i && (state_reg == IDLE) && head_valid
                       && (bus.resolve_tag_i == head_reg);
  assign res_illegal = bus.resolve_valid_i && (state_reg == IDLE) && !res_legal;
  assign mispredict  = res_legal && (bus.resolve_taken_i != taken_mem[head_reg]);
  assign correct     = res_legal && !mispredict;
  // A branch fetched alongside a mispredict is on the wrong path; drop it.
  assign alloc_eff   = alloc && !mispredict;

  always_comb begin
    count_next = count_reg;
    if (alloc_eff && !correct)
      count_next = count_reg + 1'b1;
    else if (!alloc_eff && correct)
      count_next = count_reg - 1'b1;
  end

  // ---------------- recovery FSM ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    case (state_reg)
      IDLE: begin
        if (mispredict) begin
          state_next = RECOVER;
          rcnt_next  = RCNT_INIT;
        end
      end
      RECOVER: begin
        if (rcnt_reg == '0)
          state_next = IDLE;
        else
          rcnt_next = rcnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- pointers and occupancy ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (mispredict) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_eff)
        tail_reg <= tail_reg + 1'b1;
      if (correct)
        head_reg <= head_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Per-entry valid bits; alloc and pop never target the same slot in one cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
          valid_reg[gi] <= 1'b0;
        else if (mispredict)
          valid_reg[gi] <= 1'b0;
        else if (alloc_eff && (tail_reg == TAG_W'(gi)))
          valid_reg[gi] <= 1'b1;
        else if (correct && (head_reg == TAG_W'(gi)))
          valid_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // Checkpoint payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (alloc_eff) begin
      taken_mem[tail_reg]  <= bus.spec_taken_i;
      alt_pc_mem[tail_reg] <= bus.spec_alt_pc_i;
    end
  end

  // ---------------- registered recovery pulses ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      redirect_reg    <= 1'b0;
      flush_reg       <= 1'b0;
      err_reg         <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      redirect_reg <= mispredict;
      flush_reg    <= mispredict;
      err_reg      <= res_illegal;
      if (mispredict)
        redirect_pc_reg <= alt_pc_mem[head_reg];
    end
  end

`ifdef BRANCH_SPEC_TRACKER_STATS_EN
  logic [15:0] resolve_cnt_reg, mispredict_cnt_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resolve_cnt_reg    <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (res_legal && (resolve_cnt_reg != 16'hFFFF))
        resolve_cnt_reg <= resolve_cnt_reg + 16'd1;
      if (mispredict && (mispredict_cnt_reg != 16'hFFFF))
        mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
    end
  end

  assign bus.resolve_cnt_o    = resolve_cnt_reg;
  assign bus.mispredict_cnt_o = mispredict_cnt_reg;
`endif

  assign bus.spec_ready_o  = spec_ready;
  assign bus.spec_tag_o    = tail_reg;
  assign bus.fetch_stall_o = fetch_stall;
  assign bus.count_o       = count_reg;
  assign bus.redirect_o    = redirect_reg;
  assign bus.flush_o       = flush_reg;
  assign bus.redirect_pc_o = redirect_pc_reg;
  assign bus.err_o         = err_reg;
endmodule

// File: doc/branch_spec_tracker.md
Name: branch_spec_tracker

Overview:
Front-end scheduler that tracks in-flight speculative branches flagged by the FE branch decision logic (conditional branches and BX).
- Allocates an in-order checkpoint per speculative branch at fetch and stalls fetch when checkpoints run out.
- Retires checkpoints in order as the back end resolves them.
- On a mispredict, sequences recovery: registered redirect of fetch to the saved alternate PC, a flush pulse, and a fixed fetch-stall window.

Parameters:
DEPTH, 4, number of checkpoints; power of two, minimum 2
PC_WIDTH, 16, width of fetch PC
RECOVER_CYCLES, 2, cycles spent in RECOVER after a redirect; minimum 1
TAG_W, $clog2(DEPTH), checkpoint tag width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
spec_valid_i  in  1  FE fetched a speculative branch this cycle
spec_taken_i  in  1  direction FE followed (1 = taken)
spec_alt_pc_i  in  PC_WIDTH  recovery PC: the path FE did not follow
spec_ready_o  out  1  allocation accepted this cycle
spec_tag_o  out  TAG_W  tag of the entry allocated this cycle (current tail pointer)
resolve_valid_i  in  1  BE resolved the oldest speculative branch
resolve_tag_i  in  TAG_W  tag of the resolved branch
resolve_taken_i  in  1  actual direction
redirect_o  out  1  one-cycle pulse: fetch must load redirect_pc_o
redirect_pc_o  out  PC_WIDTH  recovery PC, valid while redirect_o = 1
flush_o  out  1  one-cycle pulse coincident with redirect_o: squash all younger FE/DE contents
fetch_stall_o  out  1  FE must not advance PC
count_o  out  TAG_W+1  occupied checkpoints
err_o  out  1  one-cycle pulse: illegal resolve

Behaviour:
- Reset (asynchronous, reset_n_i = 0): FSM = IDLE, head = tail = count = 0, all checkpoint valid bits = 0.
- Outputs under reset: redirect_o = 0, flush_o = 0, err_o = 0, redirect_pc_o = 0, spec_ready_o = 1, fetch_stall_o = 0, count_o = 0.
- Reset mid-RECOVER or mid-redirect aborts immediately to these values.
- Checkpoint contents: {taken, alt_pc}. Circular buffer with head = oldest; pointers wrap modulo DEPTH.
- Allocation fires when spec_valid_i & spec_ready_o:
  - Entry written at tail; spec_tag_o = tail in the same cycle (combinational from the registered tail).
  - tail increments.
- spec_ready_o = (state == IDLE) & (count != DEPTH). It uses registered count only; there is no same-cycle bypass from a resolve.
- fetch_stall_o = (state == RECOVER) | (count == DEPTH).
- A valid resolve requires all of: state == IDLE, count != 0, resolve_tag_i == head.
  - Correct prediction (resolve_taken_i == head.taken): pop head. Takes effect next cycle; no other effect.
  - Mispredict: registered next cycle: redirect_o = 1, flush_o = 1, redirect_pc_o = head.alt_pc.
  - Mispredict also clears all entries: head = tail = count = 0, state -> RECOVER.
  - An allocation in the same cycle as a mispredicting resolve is dropped: it is a wrong-path branch and its tag is discarded.
- A simultaneous correct resolve and allocation both take effect; count is unchanged.
- Illegal resolve: resolve_valid_i with count == 0, or resolve_tag_i != head.
  - Ignored, no state change.
  - err_o pulses the next cycle.
- Any resolve_valid_i during RECOVER is a stale wrong-path resolve: silently ignored, no err_o.
- FSM:
  - IDLE -> RECOVER on mispredict.
  - RECOVER counts RECOVER_CYCLES cycles, starting the cycle redirect_o is high, then returns to IDLE.
  - No allocation is accepted in RECOVER.
- Latency:
  - Resolve to redirect: 1 cycle.
  - Redirect to first accepted allocation: RECOVER_CYCLES cycles.
  - Pop to spec_ready_o rising (when full): 1 cycle.

Optional Feature:
Macro BRANCH_SPEC_TRACKER_STATS_EN.
- Defined: adds outputs resolve_cnt_o [15:0] and mispredict_cnt_o [15:0].
  - Both increment on each valid resolve and each mispredict respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Fill: 4 allocs back-to-back (DEPTH = 4) -> spec_tag_o 0,1,2,3.
  - After the 4th: count_o = 4, spec_ready_o = 0, fetch_stall_o = 1.
  - A 5th spec_valid_i is not accepted.
- Full plus same-cycle resolve: correct resolve of tag 0 with spec_valid_i high -> alloc not accepted that cycle; next cycle spec_ready_o = 1 and count_o = 3.
- Mispredict: alloc {taken = 1, alt_pc = 16'h0042} at tag 0, then resolve tag 0 with taken = 0.
  - Next cycle: redirect_o = flush_o = 1 for exactly 1 cycle, redirect_pc_o = 16'h0042, count_o = 0.
  - fetch_stall_o high for 2 cycles, then spec_ready_o = 1.
- Wrap-around: 6 alloc/correct-resolve pairs -> tags 0,1,2,3,0,1; err_o never asserted; count_o returns to 0.
- Illegal resolves:
  - Resolve with empty tracker -> err_o pulse, no redirect.
  - Resolve tag 1 while head = 0 -> err_o pulse, count unchanged.
  - Resolve during RECOVER -> no err_o.
- Async reset asserted mid-RECOVER -> fetch_stall_o, redirect_o and count_o go to 0 immediately without waiting for a clock edge; first alloc after release gets tag 0.
